// File: rtl/rr_arb_4.sv
// rr_arb_4: four-way round-robin arbiter with hold limit.
// Registered one-hot grant decoded from a registered winner index.
module rr_arb_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CW-1:0] HLAST = CW'(MAX_HOLD - 1);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] hcnt, hcnt_n;

  logic [1:0] cand;
  logic [1:0] win;
  logic       win_vld;
  logic       rel;
  logic       frc;

  logic [1:0] idx_n;
  logic       vld_n;
  logic       to_n;
  logic [3:0] gnt_n;

  // cyclic search from ptr; descending loop so the nearest requester wins
  always_comb begin
    cand    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // release when the winner drops or the hold limit is reached
  always_comb begin
    frc = (state == BUSY) && req[gnt_idx] && (hcnt == HLAST);
    rel = (state == BUSY) && (!req[gnt_idx] || (hcnt == HLAST));
  end

  // next-state: FSM state, rotation pointer and hold counter
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hcnt_n  = hcnt;
    case (state)
      IDLE: begin
        if (en && win_vld) begin
          state_n = BUSY;
          hcnt_n  = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_n = IDLE;
          ptr_n   = gnt_idx + 2'd1;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // next outputs: winner index, valid, timeout pulse, one-hot grant
  always_comb begin
    idx_n = '0;
    vld_n = 1'b0;
    to_n  = 1'b0;
    case (state)
      IDLE: begin
        if (en && win_vld) begin
          idx_n = win;
          vld_n = 1'b1;
        end
      end
      BUSY: begin
        if (rel) begin
          to_n = frc;
        end else begin
          idx_n = gnt_idx;
          vld_n = 1'b1;
        end
      end
      default: ;
    endcase
    gnt_n = '0;
    if (vld_n) begin
      unique case (1'b1)
        (idx_n == 2'd0): gnt_n = 4'b0001;
        (idx_n == 2'd1): gnt_n = 4'b0010;
        (idx_n == 2'd2): gnt_n = 4'b0100;
        (idx_n == 2'd3): gnt_n = 4'b1000;
        default:         gnt_n = 4'b0000;
      endcase
    end
  end

  // state and output registers; reset dominates
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      hcnt    <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      hcnt    <= hcnt_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
      timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_arb_4.sv
// tb_rr_arb_4: scoreboard bench for rr_arb_4 (MAX_HOLD 8 and 1).
// Reference model pushes expected outputs; monitor pops and compares.
module tb_rr_arb_4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;

  logic [3:0] g8, g1;
  logic [1:0] i8, i1;
  logic       v8, v1;
  logic       t8, t1;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  rr_arb_4 #(.MAX_HOLD(8), .CW(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(g8), .gnt_idx(i8), .gnt_vld(v8), .timeout(t8)
  );

  rr_arb_4 #(.MAX_HOLD(1), .CW(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(g1), .gnt_idx(i1), .gnt_vld(v1), .timeout(t1)
  );

  // reference model: grant owner, cycles granted so far, rotation start
  int  mh[2]   = '{8, 1};
  bit  busy[2] = '{0, 0};
  int  own[2]  = '{0, 0};
  int  held[2] = '{0, 0};
  int  ptr[2]  = '{0, 0};
  bit  to[2]   = '{0, 0};

  always @(posedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 0; own[i] = 0; held[i] = 0; ptr[i] = 0; to[i] = 0;
      end else begin
        to[i] = 0;
        if (busy[i]) begin
          if (!req[own[i]]) begin
            busy[i] = 0;
            ptr[i]  = (own[i] + 1) % 4;
          end else if (held[i] == mh[i]) begin
            busy[i] = 0;
            to[i]   = 1;
            ptr[i]  = (own[i] + 1) % 4;
          end else begin
            held[i]++;
          end
        end else if (en && req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            if (!busy[i] && req[(ptr[i] + k) % 4]) begin
              busy[i] = 1;
              own[i]  = (ptr[i] + k) % 4;
              held[i] = 1;
            end
          end
        end
      end
      e.gnt = busy[i] ? 4'(1 << own[i]) : 4'b0000;
      e.idx = busy[i] ? 2'(own[i]) : 2'b00;
      e.vld = busy[i];
      e.to  = to[i];
      if (i == 0) q8.push_back(e);
      else        q1.push_back(e);
    end
  end

  task automatic cmp(input string nm, input exp_t got, input bit empty,
                     input exp_t ex);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s no expected entry queued", nm);
    end else if (got !== ex) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b idx=%0d vld=%b to=%b exp gnt=%b idx=%0d vld=%b to=%b",
               nm, $time, got.gnt, got.idx, got.vld, got.to,
               ex.gnt, ex.idx, ex.vld, ex.to);
    end
  endtask

  // monitor: outputs are presented every cycle, sampled 1 unit after the edge
  always begin
    exp_t a, x;
    bit   emp;
    @(posedge clk);
    #1;
    a = '{g8, i8, v8, t8};
    emp = (q8.size() == 0);
    x = emp ? exp_t'(0) : q8.pop_front();
    cmp("hold8", a, emp, x);
    a = '{g1, i1, v1, t1};
    emp = (q1.size() == 0);
    x = emp ? exp_t'(0) : q1.pop_front();
    cmp("hold1", a, emp, x);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    cyc(2);
    rst = 1'b0; en = 1'b1; req = 4'b1111;
    cyc(46);
    req = 4'b0000; cyc(3);
    req = 4'b0100; cyc(3);
    req = 4'b0000; cyc(2);
    req = 4'b0101; cyc(3);
    req = 4'b0000; cyc(2);
    en = 1'b0; req = 4'b0010; cyc(3);
    en = 1'b1; cyc(2);
    en = 1'b0; cyc(4);
    req = 4'b0000; cyc(2);
    en = 1'b1; req = 4'b1000; cyc(5);
    rst = 1'b1; req = 4'b1111; cyc(1);
    rst = 1'b0; cyc(6);
    req = 4'b0000; cyc(2);
    req = 4'b0010; cyc(6);
    req = 4'b0000; cyc(2);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) req = 4'($urandom);
      en  = ($urandom_range(9) < 8);
      rst = ($urandom_range(99) == 0);
      cyc(1);
    end
    rst = 1'b0; req = 4'b0000; cyc(4);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
